// File: rtl/rcadder_pipe_if.sv
// rcadder_pipe_if: operand/result bundle for the pipelined ripple-carry adder.
// The master side presents operations and hold, and the slave side returns results.
interface rcadder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             hold;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output carry_in,
        output sub,
        output hold,
        input  out_valid,
        input  sum,
        input  carry_out,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  carry_in,
        input  sub,
        input  hold,
        output out_valid,
        output sum,
        output carry_out,
        output overflow
    );
endinterface

// File: rtl/rcadder_pipe.sv
// rcadder_pipe: WIDTH-bit adder/subtractor built as STAGES ripple-carry chunks,
// one chunk per clock, with the chunk carry registered between stages.
// The final chunk is computed straight into the output registers, so the
// latency is STAGES cycles. A global hold freezes every register.
module rcadder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst,
    rcadder_pipe_if.slave bus
);
    localparam int C     = (STAGES > 0) ? WIDTH / STAGES : 1;
    // Inter-stage registers sit between chunks. With a single stage there are
    // none, and a one-entry array keeps the declarations legal.
    localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("rcadder_pipe: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
    end

    // One pipeline slot. Bits below the processed chunks hold finished sum
    // bits. Bits above them are still-unprocessed operand bits of a and the
    // effective b.
    typedef struct packed {
        logic             vld;
        logic             cy;
        logic             msb_ci;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    // C-bit ripple chain. The result is {carry out, carry into chunk MSB, sum}.
    function automatic logic [C+1:0] add_chunk(
        input logic [C-1:0] ac,
        input logic [C-1:0] bc,
        input logic         ci
    );
        logic [C:0]   cy;
        logic [C-1:0] s;
        cy = '0;
        s  = '0;
        cy[0] = ci;
        for (int i = 0; i < C; i++) begin
            s[i]    = ac[i] ^ bc[i] ^ cy[i];
            cy[i+1] = (ac[i] & bc[i]) | (cy[i] & (ac[i] ^ bc[i]));
        end
        return {cy[C], cy[C-1], s};
    endfunction

    stage_t [NPIPE-1:0] pipe_q;
    stage_t [NPIPE-1:0] pipe_d;
    stage_t             fin_s;

    logic               out_vld_q;
    logic               out_vld_d;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_q;
    logic               cout_d;
    logic               ovf_q;
    logic               ovf_d;

    // Chunk chain: stage k adds chunk k of its slot. The result goes to the
    // next slot, or to the output stage for the last chunk.
    always_comb begin
        stage_t       src_v;
        stage_t       res_v;
        logic [C+1:0] chunk_v;
        src_v   = '0;
        res_v   = '0;
        chunk_v = '0;
        pipe_d  = pipe_q;
        fin_s   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_v.vld    = bus.in_valid;
                src_v.cy     = bus.carry_in;
                src_v.msb_ci = 1'b0;
                src_v.s      = '0;
                src_v.a      = bus.a;
                src_v.b      = bus.sub ? ~bus.b : bus.b;
            end else begin
                src_v = pipe_q[(k > 0) ? k - 1 : 0];
            end
            chunk_v            = add_chunk(src_v.a[k*C +: C], src_v.b[k*C +: C], src_v.cy);
            res_v              = src_v;
            res_v.s[k*C +: C]  = chunk_v[C-1:0];
            res_v.msb_ci       = chunk_v[C];
            res_v.cy           = chunk_v[C+1];
            if (k < STAGES - 1) begin
                if (bus.hold) begin
                    pipe_d[(k < STAGES - 1) ? k : 0] = pipe_q[(k < STAGES - 1) ? k : 0];
                end else begin
                    pipe_d[(k < STAGES - 1) ? k : 0] = res_v;
                end
            end else begin
                fin_s = res_v;
            end
        end
    end

    // Output stage next state: load only on a valid final chunk, freeze on hold.
    always_comb begin
        out_vld_d = out_vld_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        if (bus.hold) begin
            out_vld_d = out_vld_q;
        end else begin
            out_vld_d = fin_s.vld;
            if (fin_s.vld) begin
                sum_d  = fin_s.s;
                cout_d = fin_s.cy;
                // Signed overflow: carry into the MSB differs from carry out.
                ovf_d  = fin_s.msb_ci ^ fin_s.cy;
            end else begin
                sum_d  = sum_q;
                cout_d = cout_q;
                ovf_d  = ovf_q;
            end
        end
    end

    // State registers: reset clears every slot and the outputs, discarding in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q    <= '0;
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pipe_q    <= pipe_d;
            out_vld_q <= out_vld_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // A frozen result stays in out_vld_q and reappears once hold drops.
    assign bus.out_valid = out_vld_q & ~bus.hold;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_rcadder_pipe.sv
// tb_rcadder_pipe: drives three configurations (16/4, 16/1, 8/8) with one
// shared stimulus stream. Each configuration has an in-order result scoreboard.
// The 16/4 instance also gets exact-cycle out_valid timeline checks.
module tb_rcadder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        drv_valid;
    logic        drv_hold;
    logic        drv_sub;
    logic        drv_cin;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic [17:0] drv_exp;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [9:0]  q2 [$];

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl [12];

    rcadder_pipe_if #(.WIDTH(16)) bus0 ();
    rcadder_pipe_if #(.WIDTH(16)) bus1 ();
    rcadder_pipe_if #(.WIDTH(8))  bus2 ();

    assign bus0.in_valid = drv_valid;
    assign bus0.hold     = drv_hold;
    assign bus0.sub      = drv_sub;
    assign bus0.carry_in = drv_cin;
    assign bus0.a        = drv_a;
    assign bus0.b        = drv_b;
    assign bus1.in_valid = drv_valid;
    assign bus1.hold     = drv_hold;
    assign bus1.sub      = drv_sub;
    assign bus1.carry_in = drv_cin;
    assign bus1.a        = drv_a;
    assign bus1.b        = drv_b;
    assign bus2.in_valid = drv_valid;
    assign bus2.hold     = drv_hold;
    assign bus2.sub      = drv_sub;
    assign bus2.carry_in = drv_cin;
    assign bus2.a        = drv_a[7:0];
    assign bus2.b        = drv_b[7:0];

    rcadder_pipe #(.WIDTH(16), .STAGES(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    rcadder_pipe #(.WIDTH(16), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    rcadder_pipe #(.WIDTH(8),  .STAGES(8)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic logic [17:0] model16(input logic s, input logic c,
                                            input logic [15:0] x, input logic [15:0] y);
        logic [15:0] be;
        logic [16:0] r;
        logic        ov;
        be = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, be} + {16'd0, c};
        ov = (x[15] == be[15]) && (r[15] != x[15]);
        return {ov, r};
    endfunction

    function automatic logic [9:0] model8(input logic s, input logic c,
                                          input logic [7:0] x, input logic [7:0] y);
        logic [7:0] be;
        logic [8:0] r;
        logic       ov;
        be = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, be} + {8'd0, c};
        ov = (x[7] == be[7]) && (r[7] != x[7]);
        return {ov, r};
    endfunction

    function automatic logic [15:0] pick16();
        logic [15:0] corners [4];
        corners[0] = 16'h0000;
        corners[1] = 16'hFFFF;
        corners[2] = 16'h7FFF;
        corners[3] = 16'h8000;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 3)];
        else return 16'($urandom);
    endfunction

    // Scoreboard push: every accepted operation queues its expected result.
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (drv_valid && !drv_hold) begin
            q0.push_back(drv_exp);
            q1.push_back(model16(drv_sub, drv_cin, drv_a, drv_b));
            q2.push_back(model8(drv_sub, drv_cin, drv_a[7:0], drv_b[7:0]));
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (bus0.out_valid === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL u0_unexpected: out_valid=1 result %h, expected no result", {bus0.overflow, bus0.carry_out, bus0.sum});
            end else begin
                e = q0.pop_front();
                if ({bus0.overflow, bus0.carry_out, bus0.sum} !== e)
                    begin n_fail++; $display("FAIL u0_result: got {ovf,cout,sum}=%h want %h", {bus0.overflow, bus0.carry_out, bus0.sum}, e); end
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (bus1.out_valid === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL u1_unexpected: out_valid=1 result %h, expected no result", {bus1.overflow, bus1.carry_out, bus1.sum});
            end else begin
                e = q1.pop_front();
                if ({bus1.overflow, bus1.carry_out, bus1.sum} !== e)
                    begin n_fail++; $display("FAIL u1_result: got {ovf,cout,sum}=%h want %h", {bus1.overflow, bus1.carry_out, bus1.sum}, e); end
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (bus2.out_valid === 1'b1) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL u2_unexpected: out_valid=1 result %h, expected no result", {bus2.overflow, bus2.carry_out, bus2.sum});
            end else begin
                e = q2.pop_front();
                if ({bus2.overflow, bus2.carry_out, bus2.sum} !== e)
                    begin n_fail++; $display("FAIL u2_result: got {ovf,cout,sum}=%h want %h", {bus2.overflow, bus2.carry_out, bus2.sum}, e); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_hold  = 1'b0;
        rst       = 1'b0;
    endtask

    // Check u0 out_valid (and optionally all-zero data) for this cycle, then advance.
    task automatic run_cycle(input logic exp_ov, input logic chk_zero, input string tag);
        @(negedge clk);
        n_cmp++;
        if (bus0.out_valid !== exp_ov) begin
            n_fail++;
            $display("FAIL %s_out_valid: got %b want %b", tag, bus0.out_valid, exp_ov);
        end
        if (chk_zero) begin
            n_cmp++;
            if ({bus0.sum, bus0.carry_out, bus0.overflow} !== 18'd0) begin
                n_fail++;
                $display("FAIL %s_zero: got {sum,cout,ovf}=%h want 0", tag, {bus0.sum, bus0.carry_out, bus0.overflow});
            end
        end
        tick();
    endtask

    task automatic issue(input logic s, input logic c, input logic [15:0] x,
                         input logic [15:0] y, input logic [17:0] e);
        drv_valid = 1'b1;
        drv_sub   = s;
        drv_cin   = c;
        drv_a     = x;
        drv_b     = y;
        drv_exp   = e;
    endtask

    task automatic issue_tbl(input int i);
        issue(tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
    endtask

    initial begin
        //               sub   cin   a         b         sum       cout  ovf
        tbl[0]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0003, 16'h0003, 16'hFFFF, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0};

        rst       = 1'b1;
        drv_valid = 1'b1;
        drv_hold  = 1'b0;
        drv_sub   = 1'b0;
        drv_cin   = 1'b0;
        drv_a     = 16'h0000;
        drv_b     = 16'h0000;
        drv_exp   = 18'd0;
        @(posedge clk);
        #1;

        // Reset held two cycles with live random inputs, then four idle cycles.
        for (int c = 0; c < 2; c++) begin
            rst = 1'b1; drv_valid = 1'b1; drv_sub = 1'($urandom); drv_cin = 1'($urandom);
            drv_a = 16'($urandom); drv_b = 16'($urandom);
            run_cycle(1'b0, 1'b1, "reset");
        end
        for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b1, "post_reset");

        // Full carry ripple: single pulse in cycle 4.
        issue_tbl(0);
        run_cycle(1'b0, 1'b0, "ripple");
        for (int c = 1; c <= 5; c++) run_cycle(c == 4, 1'b0, "ripple");

        // Back-to-back add then subtract.
        issue_tbl(1);
        run_cycle(1'b0, 1'b0, "b2b");
        issue_tbl(2);
        run_cycle(1'b0, 1'b0, "b2b");
        for (int c = 2; c <= 6; c++) run_cycle(c == 4 || c == 5, 1'b0, "b2b");

        // Hold mid-flight, with an operation presented during hold (dropped).
        issue_tbl(3);
        run_cycle(1'b0, 1'b0, "hold_mid");
        run_cycle(1'b0, 1'b0, "hold_mid");
        drv_hold = 1'b1; issue(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 18'd0);
        run_cycle(1'b0, 1'b0, "hold_mid");
        drv_hold = 1'b1;
        run_cycle(1'b0, 1'b0, "hold_mid");
        for (int c = 4; c <= 7; c++) run_cycle(c == 6, 1'b0, "hold_mid");

        // Hold while the result sits in the output stage.
        issue_tbl(6);
        for (int c = 0; c <= 3; c++) run_cycle(1'b0, 1'b0, "hold_out");
        drv_hold = 1'b1;
        run_cycle(1'b0, 1'b0, "hold_out");
        drv_hold = 1'b1;
        run_cycle(1'b0, 1'b0, "hold_out");
        run_cycle(1'b1, 1'b0, "hold_out");
        run_cycle(1'b0, 1'b0, "hold_out");

        // Reset mid-operation discards everything in flight.
        for (int c = 0; c < 3; c++) begin
            issue_tbl(7 + c);
            run_cycle(1'b0, 1'b0, "rst_mid");
        end
        rst = 1'b1;
        run_cycle(1'b0, 1'b0, "rst_mid");
        for (int c = 4; c <= 8; c++) run_cycle(1'b0, 1'b1, "rst_mid");

        // Whole table streamed back-to-back.
        for (int i = 0; i < 12; i++) begin
            issue_tbl(i);
            run_cycle(i >= 4, 1'b0, "table");
        end
        for (int c = 12; c <= 16; c++) run_cycle(c < 16, 1'b0, "table");

        // Random regression with bubbles and holds.
        for (int i = 0; i < 256; i++) begin
            int r;
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            logic        rc;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                drv_hold = 1'b1; drv_valid = 1'($urandom);
                drv_a = 16'($urandom); drv_b = 16'($urandom);
                tick();
            end else if (r == 1) begin
                tick();
            end
            ra = pick16(); rb = pick16(); rs = 1'($urandom); rc = 1'($urandom);
            issue(rs, rc, ra, rb, model16(rs, rc, ra, rb));
            tick();
        end
        repeat (20) tick();

        n_cmp++;
        if (q0.size() != 0) begin n_fail++; $display("FAIL u0_drain: %0d results missing, want 0", q0.size()); end
        n_cmp++;
        if (q1.size() != 0) begin n_fail++; $display("FAIL u1_drain: %0d results missing, want 0", q1.size()); end
        n_cmp++;
        if (q2.size() != 0) begin n_fail++; $display("FAIL u2_drain: %0d results missing, want 0", q2.size()); end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
